led_pattern_ctrl: RTL



---
 rtl/led_pattern_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// Command-driven sequencer for the 8-LED bank: loads patterns and sets mode, speed and run/pause.
// Steps come from a base tick prescaler and a speed sub-divider; leds and step_pulse are registered.
module led_pattern_ctrl #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int TICK_CYCLES = CLK_FREQ / 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic [7:0] leds,
  output logic       step_pulse
);

  // state   | meaning
  // RUNNING | counters advance, steps fire, commands accepted
  // PAUSED  | counters/pattern frozen, commands accepted
  // APPLY   | one cycle after an accept; latched command written on exit
  typedef enum logic [1:0] {RUNNING, PAUSED, APPLY} state_t;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [1:0] OP_LOAD      = 2'd0;
  localparam logic [1:0] OP_SET_MODE  = 2'd1;
  localparam logic [1:0] OP_SET_SPEED = 2'd2;
  localparam logic [1:0] OP_RUN_CTL   = 2'd3;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  state_t          state, nxt_state;
  logic [7:0]      pat, nxt_pat;
  logic [7:0]      nxt_leds;
  logic [1:0]      mode, nxt_mode;
  logic [2:0]      speed, nxt_speed;
  logic            run, nxt_run;
  logic            dir, nxt_dir;       // 0 = left, 1 = right
  logic            phase, nxt_phase;
  logic [TW-1:0]   tick_cnt, nxt_tick_cnt;
  logic [2:0]      sub_cnt, nxt_sub_cnt;
  logic [1:0]      op_q;
  logic [7:0]      arg_q;
  logic            accept;
  logic            step;

  assign cmd_ready = (state != APPLY);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUNNING;
      pat        <= 8'h1F;
      leds       <= 8'h1F;
      mode       <= MODE_ROT_L;
      speed      <= 3'd7;
      run        <= 1'b1;
      dir        <= 1'b0;
      phase      <= 1'b0;
      tick_cnt   <= '0;
      sub_cnt    <= '0;
      step_pulse <= 1'b0;
      op_q       <= '0;
      arg_q      <= '0;
    end else begin
      state      <= nxt_state;
      pat        <= nxt_pat;
      leds       <= nxt_leds;
      mode       <= nxt_mode;
      speed      <= nxt_speed;
      run        <= nxt_run;
      dir        <= nxt_dir;
      phase      <= nxt_phase;
      tick_cnt   <= nxt_tick_cnt;
      sub_cnt    <= nxt_sub_cnt;
      step_pulse <= step;
      if (accept) begin
        op_q  <= cmd_op;
        arg_q <= cmd_arg;
      end
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_pat      = pat;
    nxt_mode     = mode;
    nxt_speed    = speed;
    nxt_run      = run;
    nxt_dir      = dir;
    nxt_phase    = phase;
    nxt_tick_cnt = tick_cnt;
    nxt_sub_cnt  = sub_cnt;
    step         = 1'b0;

    case (state)
      RUNNING: begin
        if (tick_cnt == TICK_LAST && sub_cnt == speed) begin
          step         = 1'b1;
          nxt_tick_cnt = '0;
          nxt_sub_cnt  = '0;
        end else if (tick_cnt == TICK_LAST) begin
          nxt_tick_cnt = '0;
          nxt_sub_cnt  = sub_cnt + 3'd1;
        end else begin
          nxt_tick_cnt = tick_cnt + TW'(1);
        end
        if (accept) nxt_state = APPLY;
      end
      PAUSED: begin
        if (accept) nxt_state = APPLY;
      end
      APPLY: begin
        case (op_q)
          OP_LOAD: begin
            nxt_pat      = arg_q;
            nxt_tick_cnt = '0;
            nxt_sub_cnt  = '0;
            nxt_dir      = 1'b0;
            nxt_phase    = 1'b0;
          end
          OP_SET_MODE: begin
            nxt_mode  = arg_q[1:0];
            nxt_dir   = 1'b0;
            nxt_phase = 1'b0;
          end
          OP_SET_SPEED: begin
            nxt_speed    = arg_q[2:0];
            nxt_tick_cnt = '0;
            nxt_sub_cnt  = '0;
          end
          default: nxt_run = arg_q[0];
        endcase
        nxt_state = nxt_run ? RUNNING : PAUSED;
      end
      default: nxt_state = RUNNING;
    endcase

    if (step) begin
      case (mode)
        MODE_ROT_L: nxt_pat = {pat[6:0], pat[7]};
        MODE_ROT_R: nxt_pat = {pat[0], pat[7:1]};
        MODE_BOUNCE: begin
          // Reverse before a lit LED would fall off an end; stuck both ways only flips dir.
          if (!dir) begin
            if (!pat[7]) nxt_pat = {pat[6:0], 1'b0};
            else if (!pat[0]) begin
              nxt_pat = {1'b0, pat[7:1]};
              nxt_dir = 1'b1;
            end else nxt_dir = 1'b1;
          end else begin
            if (!pat[0]) nxt_pat = {1'b0, pat[7:1]};
            else if (!pat[7]) begin
              nxt_pat = {pat[6:0], 1'b0};
              nxt_dir = 1'b0;
            end else nxt_dir = 1'b0;
          end
        end
        default: nxt_phase = ~phase;
      endcase
    end

    nxt_leds = (nxt_mode == MODE_BLINK && nxt_phase) ? 8'h00 : nxt_pat;
  end

endmodule
